// File: rtl/lcd_cmd_host_pkg.sv
// Shared definitions for the LCD command host: command codes, FSM states and image geometry.
package lcd_cmd_host_pkg;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int IMG_SIZE = IMG_W * IMG_H;
    localparam int CAP_CNT_W = 7;
    localparam logic [CAP_CNT_W-1:0] CAP_FULL = CAP_CNT_W'(IMG_SIZE);

    localparam logic [2:0] CMD_WRITE       = 3'd0;
    localparam logic [2:0] CMD_SHIFT_UP    = 3'd1;
    localparam logic [2:0] CMD_SHIFT_DOWN  = 3'd2;
    localparam logic [2:0] CMD_SHIFT_LEFT  = 3'd3;
    localparam logic [2:0] CMD_SHIFT_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG         = 3'd5;
    localparam logic [2:0] CMD_MIR_X       = 3'd6;
    localparam logic [2:0] CMD_MIR_Y       = 3'd7;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        ISSUE  = 3'd2,
        GUARD  = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/lcd_cmd_host_fifo.sv
// Synchronous FIFO for queued LCD commands; head is visible combinationally.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_host.sv
// Queues upstream commands, issues them to the LCD controller, and captures the written-out frame.
module lcd_cmd_host
    import lcd_cmd_host_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_valid,
    input  logic [2:0] push_cmd,
    output logic       push_ready,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       IRB_RW,
    input  logic [5:0] IRB_A,
    input  logic [7:0] IRB_D,
    input  logic       done,
    input  logic [5:0] cap_addr,
    output logic [7:0] cap_data,
    output logic       frame_done,
    output logic       ovf_err,
    output logic       short_err
);
    state_t state, state_next;

    logic       fifo_full, fifo_empty, pop, push_acc;
    logic [2:0] fifo_head;

    logic [7:0]           cap_mem [IMG_SIZE];
    logic [CAP_CNT_W-1:0] cap_cnt;

    // A pop in the same cycle frees a slot, so a full queue can still take a push.
    assign pop        = (state == ISSUE);
    assign push_ready = !fifo_full || pop;
    assign push_acc   = push_valid && push_ready;

    lcd_cmd_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(3)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_acc),
        .pop  (pop),
        .din  (push_cmd),
        .head (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        case (state)
            INIT:   if (!busy) state_next = IDLE;
            IDLE:   if (!fifo_empty && !busy) state_next = ISSUE;
            ISSUE: begin
                cmd_valid  = 1'b1;
                state_next = (cmd == CMD_WRITE) ? WRITE : GUARD;
            end
            GUARD:  state_next = IDLE;
            WRITE:  if (done) state_next = FINISH;
            FINISH: state_next = FINISH;
            default: state_next = INIT;
        endcase
    end

    // cmd is latched on entry to ISSUE and held until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    cmd <= CMD_WRITE;
        else if (state == IDLE && state_next == ISSUE) cmd <= fifo_head;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err    <= 1'b0;
            frame_done <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            if (push_valid && !push_ready) ovf_err <= 1'b1;
            if (state == WRITE && done) begin
                if (cap_cnt == CAP_FULL) frame_done <= 1'b1;
                else                     short_err  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!IRB_RW) cap_mem[IRB_A] <= IRB_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            cap_cnt <= '0;
        else if (!IRB_RW && cap_cnt != CAP_FULL) cap_cnt <= cap_cnt + 1'b1;
    end

    assign cap_data = cap_mem[cap_addr];

endmodule
